// File: rtl/blackjack_pkg.sv
// Shared blackjack types: deck geometry, card owner tags, dealer FSM states
// and the card record, plus the index -> rank/suit mapping.
package blackjack_pkg;

  localparam int DECK_SIZE  = 52;
  localparam int RANKS      = 13;
  localparam int SUITS      = 4;
  localparam int CARD_IDX_W = 6;

  typedef enum logic {
    PLAYER = 1'b0,
    DEALER = 1'b1
  } owner_e;

  typedef enum logic [2:0] {
    IDLE,
    RNG_REQ,
    RNG_WAIT,
    PROBE,
    DELIVER
  } state_e;

  typedef struct packed {
    logic [5:0] index;
    logic [3:0] rank;
    logic [1:0] suit;
  } card_t;

  // Suit by threshold compare; rank is the offset within the suit, 1-based.
  function automatic card_t card_from_index(input logic [5:0] idx);
    card_t      c;
    logic [5:0] base;
    if (idx >= 6'(3 * RANKS)) begin
      c.suit = 2'd3;
      base   = 6'(3 * RANKS);
    end else if (idx >= 6'(2 * RANKS)) begin
      c.suit = 2'd2;
      base   = 6'(2 * RANKS);
    end else if (idx >= 6'(RANKS)) begin
      c.suit = 2'd1;
      base   = 6'(RANKS);
    end else begin
      c.suit = 2'd0;
      base   = 6'd0;
    end
    c.index = idx;
    c.rank  = 4'(idx - base) + 4'd1;
    return c;
  endfunction

endpackage

// File: rtl/deck_tracker.sv
// Dealt-card bitmap and undealt-card counter for one deck.
// A clear returns every card; a mark removes one undealt card.
module deck_tracker #(
  parameter int DECK_SIZE = 52,
  parameter int IDX_W     = 6,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear,
  input  logic             markValid,
  input  logic [IDX_W-1:0] markIndex,
  input  logic [IDX_W-1:0] queryIndex,
  output logic             queryDealt,
  output logic [CNT_W-1:0] cardsLeft
);

  logic [DECK_SIZE-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     count_q, count_d;

  always_comb begin
    mask_d  = mask_q;
    count_d = count_q;
    if (clear) begin
      mask_d  = '0;
      count_d = CNT_W'(DECK_SIZE);
    end else if (markValid && !mask_q[markIndex]) begin
      // Guarded so a repeated mark can never drive the counter below the mask.
      mask_d[markIndex] = 1'b1;
      count_d           = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mask_q  <= '0;
      count_q <= CNT_W'(DECK_SIZE);
    end else begin
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  assign queryDealt = mask_q[queryIndex];
  assign cardsLeft  = count_q;

endmodule

// File: rtl/card_dealer_arbiter.sv
// Round-robin card dealer for the player and dealer hands: pulses the shared
// RNG, folds its value into the deck, linear-probes to an undealt card.
module card_dealer_arbiter #(
  parameter int DECK_SIZE = 52,
  parameter int RNG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 playerReq,
  input  logic                 dealerReq,
  input  logic                 shuffle,
  input  logic [RNG_WIDTH-1:0] rngValue,
  output logic                 rngRequest,
  output logic                 cardValid,
  output logic                 cardOwner,
  output logic                 deckEmpty,
  output logic [5:0]           cardIndex,
  output logic [3:0]           cardRank,
  output logic [1:0]           cardSuit,
  output logic [5:0]           cardsLeft
);

  import blackjack_pkg::*;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_owner_q, last_owner_d;
  owner_e                out_owner_q, out_owner_d;
  logic                  pending_q, pending_d;
  logic [CARD_IDX_W-1:0] probe_q, probe_d;
  logic                  rng_req_q, rng_req_d;
  logic                  valid_q, valid_d;
  logic                  empty_q, empty_d;
  card_t                 card_q, card_d;

  logic   deck_clear;
  logic   deck_mark;
  logic   probe_dealt;
  logic   any_req;
  owner_e grant;

  deck_tracker #(
    .DECK_SIZE (DECK_SIZE),
    .IDX_W     (CARD_IDX_W),
    .CNT_W     (6)
  ) u_deck (
    .clk        (clk),
    .resetN     (resetN),
    .clear      (deck_clear),
    .markValid  (deck_mark),
    .markIndex  (probe_q),
    .queryIndex (probe_q),
    .queryDealt (probe_dealt),
    .cardsLeft  (cardsLeft)
  );

  assign any_req = playerReq | dealerReq;

  // On a tie the side not served last goes first.
  always_comb begin
    if (playerReq && dealerReq) begin
      grant = (last_owner_q == DEALER) ? PLAYER : DEALER;
    end else if (dealerReq) begin
      grant = DEALER;
    end else begin
      grant = PLAYER;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    out_owner_d  = PLAYER;
    pending_d    = pending_q | shuffle;
    probe_d      = probe_q;
    rng_req_d    = 1'b0;
    valid_d      = 1'b0;
    empty_d      = 1'b0;
    card_d       = '0;
    deck_clear   = 1'b0;
    deck_mark    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending_q || shuffle) begin
          deck_clear = 1'b1;
          pending_d  = 1'b0;
        end else if (any_req && cardsLeft == '0) begin
          valid_d     = 1'b1;
          empty_d     = 1'b1;
          out_owner_d = grant;
        end else if (any_req) begin
          owner_d   = grant;
          rng_req_d = 1'b1;
          state_d   = RNG_REQ;
        end
      end
      RNG_REQ: state_d = RNG_WAIT;
      RNG_WAIT: begin
        // 2^RNG_WIDTH <= 2*DECK_SIZE, so a single subtraction lands in range.
        if (rngValue < RNG_WIDTH'(DECK_SIZE)) begin
          probe_d = CARD_IDX_W'(rngValue);
        end else begin
          probe_d = CARD_IDX_W'(rngValue - RNG_WIDTH'(DECK_SIZE));
        end
        state_d = PROBE;
      end
      PROBE: begin
        if (!probe_dealt) begin
          deck_mark    = 1'b1;
          valid_d      = 1'b1;
          out_owner_d  = owner_q;
          card_d       = card_from_index(probe_q);
          last_owner_d = owner_q;
          state_d      = DELIVER;
        end else if (probe_q == CARD_IDX_W'(DECK_SIZE - 1)) begin
          probe_d = '0;
        end else begin
          probe_d = probe_q + CARD_IDX_W'(1);
        end
      end
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      owner_q      <= PLAYER;
      last_owner_q <= DEALER;
      out_owner_q  <= PLAYER;
      pending_q    <= 1'b0;
      probe_q      <= '0;
      rng_req_q    <= 1'b0;
      valid_q      <= 1'b0;
      empty_q      <= 1'b0;
      card_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      out_owner_q  <= out_owner_d;
      pending_q    <= pending_d;
      probe_q      <= probe_d;
      rng_req_q    <= rng_req_d;
      valid_q      <= valid_d;
      empty_q      <= empty_d;
      card_q       <= card_d;
    end
  end

  assign rngRequest = rng_req_q;
  assign cardValid  = valid_q;
  assign cardOwner  = out_owner_q;
  assign deckEmpty  = empty_q;
  assign cardIndex  = card_q.index;
  assign cardRank   = card_q.rank;
  assign cardSuit   = card_q.suit;

endmodule

// File: doc/card_dealer_arbiter.md
# card_dealer_arbiter

Sequences the shared random number generator on behalf of the two card consumers in the blackjack design, player hand logic and dealer hand logic. Arbitrates their card requests, pulses the generator, and maps the sampled value to a card not yet dealt in the current deck. Delivers that card with rank, suit and owner tag. Tracks the dealt set until a shuffle clears it.

## Interface
Parameters:
- DECK_SIZE, 52, cards per deck; card index range 0..DECK_SIZE-1
- RNG_WIDTH, 6, width of generator value; requires DECK_SIZE ≤ 2^RNG_WIDTH ≤ 2·DECK_SIZE

Ports:
- clk  in  1  system clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- playerReq  in  1  level; player wants one card; held until its cardValid
- dealerReq  in  1  level; dealer wants one card; held until its cardValid
- shuffle  in  1  one-cycle pulse; return all cards to deck
- rngValue  in  RNG_WIDTH  current generator output
- rngRequest  out  1  one-cycle pulse; generator latches new value on its rising edge
- cardValid  out  1  one-cycle pulse; result for cardOwner
- cardOwner  out  1  0 = player, 1 = dealer
- deckEmpty  out  1  qualifies cardValid: no card available, card fields are 0
- cardIndex  out  6  dealt card, 0..51
- cardRank  out  4  cardIndex mod 13, plus 1; range 1..13 (1 = ace)
- cardSuit  out  2  cardIndex div 13
- cardsLeft  out  6  undealt cards, 52 after reset or shuffle

## Operation
- States: IDLE, RNG_REQ, RNG_WAIT, PROBE, DELIVER.
- IDLE, checked in this priority order:
  - Pending or current shuffle: clear the dealt mask, set cardsLeft = 52, stay IDLE. Requests are not served that cycle.
  - Request present and cardsLeft = 0: one-cycle cardValid with deckEmpty = 1 to the arbitrated owner. Stay IDLE.
  - Request present otherwise: latch the arbitrated owner, go to RNG_REQ.
- Arbitration: round-robin. Sole requester wins. On a tie, the owner not served last wins. lastOwner resets to dealer, so the player wins the first tie.
- RNG_REQ: rngRequest = 1, go to RNG_WAIT.
- RNG_WAIT: rngRequest = 0, go to PROBE. Load probe index = rngValue if rngValue < 52, else rngValue − 52. One subtract suffices; result is always in 0..51.
- PROBE:
  - If mask[probe] is clear, go to DELIVER.
  - Else probe = probe + 1, wrapping 51 → 0, and stay in PROBE.
  - Terminates within 52 cycles, because cardsLeft > 0 is guaranteed on entry.
- DELIVER:
  - cardValid = 1, deckEmpty = 0; owner and card fields driven.
  - Set mask[probe], decrement cardsLeft, update lastOwner.
  - Return to IDLE.
- Shuffle arriving outside IDLE sets shufflePending. The deal in flight completes normally; the clear happens in the next IDLE cycle.
- Requests dropped mid-deal: the deal still completes and is delivered to the latched owner.
- Reset, asynchronous:
  - State IDLE, mask all 0, cardsLeft = 52, lastOwner = dealer, shufflePending = 0.
  - All outputs 0 except cardsLeft.
  - Reset mid-deal abandons the deal; no card is marked dealt.

## Timing
- All outputs are registered.
- Grant decided in IDLE at cycle T. rngRequest high during T+1. Probe index loaded at the end of T+2.
- Free first probe: cardValid high during T+4. Each occupied probe adds one cycle; worst case T+55.
- Empty-deck response: cardValid + deckEmpty during T+1.
- Requester must see cardValid with its own owner bit before deasserting. A request still high in the IDLE cycle after cardValid counts as a new request.
- cardsLeft and mask update on the same edge that raises cardValid.
- Shuffle clear takes effect on the edge ending the IDLE cycle in which it is executed.

## Structure
- Shared package blackjack_pkg:
  - DECK_SIZE, RANKS = 13, SUITS = 4.
  - Owner enum: PLAYER = 0, DEALER = 1.
  - State enum of this block.
  - Card struct: index, rank, suit.
- Sub-module deck_tracker holds the 52-bit dealt mask and the cardsLeft counter. Interface:
  - Inputs: clear, markValid, markIndex, queryIndex.
  - Outputs: queryDealt, cardsLeft.
- The FSM, arbiter and index reduction stay in card_dealer_arbiter.

## Test plan
- Reset, playerReq only, rngValue = 5 → rngRequest pulse at T+1; cardValid at T+4 with owner 0, index 5, rank 6, suit 0; cardsLeft 51.
- Card 5 dealt, dealerReq, rngValue = 5 → one extra probe; cardValid at T+5 with index 6, owner 1.
- rngValue = 63 → index 11. Card 51 dealt and rngValue = 51 → wraps to index 0.
- playerReq and dealerReq held together for four deals → owners alternate 0, 1, 0, 1.
- Deal all 52 cards, then one more request → cardValid + deckEmpty at T+1, cardsLeft 0. Then shuffle → cardsLeft 52, next deal succeeds.
- Shuffle during PROBE → the in-flight card is delivered, then the mask clears and cardsLeft = 52. resetN low mid-deal → no cardValid, cardsLeft 52.
